// File: rtl/m2_serial_adder.sv
// Bit-serial adder: one full-adder slice (two half-adders + OR) with a registered carry, LSB first.
// Optional signed-overflow output is built only when M2_SERIAL_ADDER_OVF_EN is defined.
module m2_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             valid_o,
  input  logic             ready_i
`ifdef M2_SERIAL_ADDER_OVF_EN
  ,
  output logic             overflow_o
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-2:0] sum_sh_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;

  logic             ha0_sum, ha0_carry, ha1_carry;
  logic             bit_sum, carry_next, last_bit;
  logic [WIDTH-1:0] sum_cat;

  // Two half-adders plus an OR form the only adder slice in the datapath.
  assign ha0_sum    = a_reg[0] ^ b_reg[0];
  assign ha0_carry  = a_reg[0] & b_reg[0];
  assign bit_sum    = ha0_sum ^ carry_reg;
  assign ha1_carry  = ha0_sum & carry_reg;
  assign carry_next = ha0_carry | ha1_carry;
  assign sum_cat    = {bit_sum, sum_sh_reg};
  assign last_bit   = (state_reg == RUN) && (cnt_reg == LAST_CNT);

  assign ready_o = (state_reg == IDLE) && rst_n_i;
  assign valid_o = (state_reg == DONE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (valid_i)  state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    if (ready_i)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_reg      <= '0;
      b_reg      <= '0;
      sum_sh_reg <= '0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
      sum_o      <= '0;
      cout_o     <= 1'b0;
`ifdef M2_SERIAL_ADDER_OVF_EN
      overflow_o <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (valid_i) begin
            a_reg     <= a_i;
            b_reg     <= b_i;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          a_reg      <= a_reg >> 1;
          b_reg      <= b_reg >> 1;
          sum_sh_reg <= sum_cat[WIDTH-1:1];
          carry_reg  <= carry_next;
          // Counter saturates at the last bit rather than wrapping.
          if (!last_bit) cnt_reg <= cnt_reg + CW'(1);
          if (last_bit) begin
            sum_o  <= sum_cat;
            cout_o <= carry_next;
`ifdef M2_SERIAL_ADDER_OVF_EN
            overflow_o <= carry_reg ^ carry_next;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_m2_serial_adder.sv
// Directed self-checking bench for m2_serial_adder (WIDTH=8).
module tb_m2_serial_adder;
  localparam int WIDTH = 8;

  logic             clk_i = 1'b0;
  logic             rst_n_i = 1'b0;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic [WIDTH-1:0] a_i = '0;
  logic [WIDTH-1:0] b_i = '0;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;
  logic             valid_o;
  logic             ready_i = 1'b0;
`ifdef M2_SERIAL_ADDER_OVF_EN
  logic             overflow_o;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  m2_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a_i),
    .b_i     (b_i),
    .sum_o   (sum_o),
    .cout_o  (cout_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
`ifdef M2_SERIAL_ADDER_OVF_EN
    ,
    .overflow_o(overflow_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Stimulus helper only: presents operands for one edge, returns at the negedge after acceptance.
  task automatic start_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    valid_i = 1'b1;
    a_i = a;
    b_i = b;
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk_i);
    tests_run++;
    if (ready_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b want 0", ready_o); end
    tests_run++;
    if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    tests_run++;
    if ({cout_o, sum_o} !== 9'h000) begin tests_failed++; $display("FAIL reset_sum: got %b/%h want 0/00", cout_o, sum_o); end
`ifdef M2_SERIAL_ADDER_OVF_EN
    tests_run++;
    if (overflow_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b want 0", overflow_o); end
`endif
    rst_n_i = 1'b1;
    @(negedge clk_i);
    tests_run++;
    if (ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_release_ready: got %b want 1", ready_o); end
    $display("[TB] reset: ready_o=%b valid_o=%b", ready_o, valid_o);
  endtask

  task automatic test_basic;
    start_add(8'h0F, 8'h01);
    repeat (WIDTH - 1) @(negedge clk_i);
    tests_run++;
    if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL basic_early_valid: got %b want 0", valid_o); end
    tests_run++;
    if (ready_o !== 1'b0) begin tests_failed++; $display("FAIL basic_run_ready: got %b want 0", ready_o); end
    @(negedge clk_i);
    tests_run++;
    if (valid_o !== 1'b1) begin tests_failed++; $display("FAIL basic_latency: got %b want 1", valid_o); end
    tests_run++;
    if ({cout_o, sum_o} !== {1'b0, 8'h10}) begin tests_failed++; $display("FAIL basic_sum: got %b/%h want 0/10", cout_o, sum_o); end
`ifdef M2_SERIAL_ADDER_OVF_EN
    tests_run++;
    if (overflow_o !== 1'b0) begin tests_failed++; $display("FAIL basic_ovf: got %b want 0", overflow_o); end
`endif
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    tests_run++;
    if ({valid_o, ready_o} !== 2'b01) begin tests_failed++; $display("FAIL basic_handshake: got valid=%b ready=%b want 0/1", valid_o, ready_o); end
    $display("[TB] add 0F+01 -> sum=%h cout=%b", sum_o, cout_o);
  endtask

  task automatic test_carry;
    start_add(8'hFF, 8'h01);
    repeat (WIDTH) @(negedge clk_i);
    tests_run++;
    if ({valid_o, cout_o, sum_o} !== {1'b1, 1'b1, 8'h00}) begin tests_failed++; $display("FAIL carry_ff01: got v=%b c=%b s=%h want 1/1/00", valid_o, cout_o, sum_o); end
`ifdef M2_SERIAL_ADDER_OVF_EN
    tests_run++;
    if (overflow_o !== 1'b0) begin tests_failed++; $display("FAIL carry_ff01_ovf: got %b want 0", overflow_o); end
`endif
    $display("[TB] add FF+01 -> sum=%h cout=%b", sum_o, cout_o);
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    start_add(8'h7F, 8'h01);
    repeat (WIDTH) @(negedge clk_i);
    tests_run++;
    if ({valid_o, cout_o, sum_o} !== {1'b1, 1'b0, 8'h80}) begin tests_failed++; $display("FAIL carry_7f01: got v=%b c=%b s=%h want 1/0/80", valid_o, cout_o, sum_o); end
`ifdef M2_SERIAL_ADDER_OVF_EN
    tests_run++;
    if (overflow_o !== 1'b1) begin tests_failed++; $display("FAIL carry_7f01_ovf: got %b want 1", overflow_o); end
`endif
    $display("[TB] add 7F+01 -> sum=%h cout=%b", sum_o, cout_o);
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
  endtask

  task automatic test_backpressure;
    start_add(8'hAA, 8'h55);
    repeat (WIDTH) @(negedge clk_i);
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if ({valid_o, cout_o, sum_o} !== {1'b1, 1'b0, 8'hFF}) begin tests_failed++; $display("FAIL backpressure_hold[%0d]: got v=%b c=%b s=%h want 1/0/FF", i, valid_o, cout_o, sum_o); end
      @(negedge clk_i);
    end
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    tests_run++;
    if ({valid_o, ready_o} !== 2'b01) begin tests_failed++; $display("FAIL backpressure_release: got valid=%b ready=%b want 0/1", valid_o, ready_o); end
    $display("[TB] add AA+55 held 5 cycles -> sum=%h", sum_o);
  endtask

  task automatic test_ignore_valid;
    int bad_ready;
    bad_ready = 0;
    start_add(8'h12, 8'h34);
    valid_i = 1'b1;
    a_i = 8'hFF;
    b_i = 8'hFF;
    tests_run++;
    if (sum_o !== 8'hFF) begin tests_failed++; $display("FAIL ignore_stale_hold: got %h want FF", sum_o); end
    for (int i = 0; i < WIDTH + 2; i++) begin
      if (ready_o !== 1'b0) bad_ready++;
      @(negedge clk_i);
    end
    tests_run++;
    if (bad_ready != 0) begin tests_failed++; $display("FAIL ignore_ready_low: got %0d cycles with ready_o=1 want 0", bad_ready); end
    tests_run++;
    if ({valid_o, cout_o, sum_o} !== {1'b1, 1'b0, 8'h46}) begin tests_failed++; $display("FAIL ignore_result: got v=%b c=%b s=%h want 1/0/46", valid_o, cout_o, sum_o); end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    $display("[TB] add 12+34 with valid_i held -> sum=%h", sum_o);
  endtask

  task automatic test_mid_reset;
    start_add(8'h55, 8'h22);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    tests_run++;
    if ({valid_o, ready_o, cout_o, sum_o} !== 11'h000) begin tests_failed++; $display("FAIL midreset_outputs: got v=%b r=%b c=%b s=%h want 0/0/0/00", valid_o, ready_o, cout_o, sum_o); end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    tests_run++;
    if ({valid_o, ready_o, sum_o} !== {1'b0, 1'b1, 8'h00}) begin tests_failed++; $display("FAIL midreset_release: got v=%b r=%b s=%h want 0/1/00", valid_o, ready_o, sum_o); end
    start_add(8'h03, 8'h04);
    repeat (WIDTH - 1) @(negedge clk_i);
    tests_run++;
    if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL midreset_early_valid: got %b want 0", valid_o); end
    @(negedge clk_i);
    tests_run++;
    if ({valid_o, cout_o, sum_o} !== {1'b1, 1'b0, 8'h07}) begin tests_failed++; $display("FAIL midreset_next_add: got v=%b c=%b s=%h want 1/0/07", valid_o, cout_o, sum_o); end
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    $display("[TB] reset mid-run, then 03+04 -> sum=%h", sum_o);
  endtask

  task automatic test_back_to_back;
    ready_i = 1'b1;
    start_add(8'h01, 8'h02);
    repeat (WIDTH) @(negedge clk_i);
    tests_run++;
    if ({valid_o, sum_o} !== {1'b1, 8'h03}) begin tests_failed++; $display("FAIL b2b_first: got v=%b s=%h want 1/03", valid_o, sum_o); end
    @(negedge clk_i);
    tests_run++;
    if ({valid_o, ready_o} !== 2'b01) begin tests_failed++; $display("FAIL b2b_return_idle: got valid=%b ready=%b want 0/1", valid_o, ready_o); end
    start_add(8'h80, 8'h80);
    repeat (WIDTH) @(negedge clk_i);
    tests_run++;
    if ({valid_o, cout_o, sum_o} !== {1'b1, 1'b1, 8'h00}) begin tests_failed++; $display("FAIL b2b_second: got v=%b c=%b s=%h want 1/1/00", valid_o, cout_o, sum_o); end
`ifdef M2_SERIAL_ADDER_OVF_EN
    tests_run++;
    if (overflow_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_second_ovf: got %b want 1", overflow_o); end
`endif
    @(negedge clk_i);
    ready_i = 1'b0;
    $display("[TB] back-to-back 01+02, 80+80 -> sum=%h cout=%b", sum_o, cout_o);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_ignore_valid();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
